// File: rtl/input_debouncer.sv
// ---------------------------------------------------------------------------
// input_debouncer
// Multi-channel switch/push-button conditioner. Each raw input is brought
// into the clk domain by a 2-flop synchronizer. A per-channel debounce FSM
// then accepts a level change only after DEBOUNCE_CYCLES consecutive
// differing synchronized samples.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   raw_in     in   [WIDTH] asynchronous switch/button levels
//   clean_out  out  [WIDTH] debounced levels (registered)
//   rise_pulse out  [WIDTH] one-cycle pulse on clean_out 0->1 (registered)
//   fall_pulse out  [WIDTH] one-cycle pulse on clean_out 1->0 (registered)
//
// Build option:
//   DEBOUNCE_EDGE_PULSE_EN - when defined, the edge pulses are generated.
//   When undefined, the pulse outputs are tied to 0 and no pulse flops
//   exist. clean_out behaves the same in both builds.
// ---------------------------------------------------------------------------
module input_debouncer #(
   parameter int unsigned WIDTH           = 2,
   parameter int unsigned DEBOUNCE_CYCLES = 50000,
   parameter int unsigned CNT_W           = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] raw_in,
   output logic [WIDTH-1:0] clean_out,
   output logic [WIDTH-1:0] rise_pulse,
   output logic [WIDTH-1:0] fall_pulse
);

   localparam logic [CNT_W-1:0] LP_DB_CNT = CNT_W'(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] LP_ONE    = CNT_W'(1);
   localparam bit               LP_IMMED  = (DEBOUNCE_CYCLES == 1);

   typedef enum logic [1:0] {
      S0  = 2'd0,   // stable low
      W01 = 2'd1,   // qualifying a rise
      S1  = 2'd2,   // stable high
      W10 = 2'd3    // qualifying a fall
   } state_t;

   logic [WIDTH-1:0] r_s1;
   logic [WIDTH-1:0] r_sq;

   // Two-flop synchronizer; the FSMs only ever look at r_sq
   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1 <= '0;
         r_sq <= '0;
      end else begin
         r_s1 <= raw_in;
         r_sq <= r_s1;
      end
   end

   for (genvar g = 0; g < WIDTH; g++) begin : g_ch
      state_t           r_state;
      state_t           w_state_nxt;
      logic [CNT_W-1:0] r_cnt;
      logic [CNT_W-1:0] w_cnt_nxt;
      logic             w_commit;
      logic             r_clean;
      logic             w_clean_nxt;

      // State register (clean level is registered alongside the state)
      always_ff @(posedge clk) begin
         if (rst) begin
            r_state <= S0;
            r_cnt   <= '0;
            r_clean <= 1'b0;
         end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_clean <= w_clean_nxt;
         end
      end

      // Next-state: count consecutive differing samples, commit at the limit
      always_comb begin
         w_state_nxt = r_state;
         w_cnt_nxt   = r_cnt;
         w_commit    = 1'b0;
         case (r_state)
            S0: begin
               if (r_sq[g]) begin
                  if (LP_IMMED) begin
                     w_state_nxt = S1;
                     w_commit    = 1'b1;
                  end else begin
                     w_state_nxt = W01;
                     w_cnt_nxt   = LP_ONE;
                  end
               end
            end
            W01: begin
               if (r_sq[g]) begin
                  if ((r_cnt + LP_ONE) == LP_DB_CNT) begin
                     w_state_nxt = S1;
                     w_cnt_nxt   = '0;
                     w_commit    = 1'b1;
                  end else begin
                     w_cnt_nxt = r_cnt + LP_ONE;
                  end
               end else begin
                  // Glitch: drop the partial qualification
                  w_state_nxt = S0;
                  w_cnt_nxt   = '0;
               end
            end
            S1: begin
               if (!r_sq[g]) begin
                  if (LP_IMMED) begin
                     w_state_nxt = S0;
                     w_commit    = 1'b1;
                  end else begin
                     w_state_nxt = W10;
                     w_cnt_nxt   = LP_ONE;
                  end
               end
            end
            W10: begin
               if (!r_sq[g]) begin
                  if ((r_cnt + LP_ONE) == LP_DB_CNT) begin
                     w_state_nxt = S0;
                     w_cnt_nxt   = '0;
                     w_commit    = 1'b1;
                  end else begin
                     w_cnt_nxt = r_cnt + LP_ONE;
                  end
               end else begin
                  w_state_nxt = S1;
                  w_cnt_nxt   = '0;
               end
            end
            default: begin
               w_state_nxt = S0;
               w_cnt_nxt   = '0;
            end
         endcase
      end

`ifdef DEBOUNCE_EDGE_PULSE_EN
      logic r_rise;
      logic r_fall;
      logic w_rise_nxt;
      logic w_fall_nxt;
`endif

      // Output decode: a commit toggles the level and flags the edge direction
      always_comb begin
         w_clean_nxt = r_clean ^ w_commit;
`ifdef DEBOUNCE_EDGE_PULSE_EN
         w_rise_nxt  = w_commit & ~r_clean;
         w_fall_nxt  = w_commit &  r_clean;
`endif
      end

      assign clean_out[g] = r_clean;

`ifdef DEBOUNCE_EDGE_PULSE_EN
      // Pulse flops; reset clears them without emitting an edge
      always_ff @(posedge clk) begin
         if (rst) begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
         end else begin
            r_rise <= w_rise_nxt;
            r_fall <= w_fall_nxt;
         end
      end

      assign rise_pulse[g] = r_rise;
      assign fall_pulse[g] = r_fall;
`else
      assign rise_pulse[g] = 1'b0;
      assign fall_pulse[g] = 1'b0;
`endif
   end

endmodule

// File: doc/input_debouncer.md
Name: input_debouncer

Overview:
- Two-channel switch/push-button conditioner for the lab-board logic-gate designs.
- Each raw board input passes through a 2-flop synchronizer, then a per-channel debounce FSM.
- Drives stable levels straight into the gate under test: clean_out[0] → A, clean_out[1] → B.
- Also produces single-cycle edge pulses for downstream counters and LEDs.

Parameters:
- WIDTH, 2: number of independent channels.
- DEBOUNCE_CYCLES, 50000: consecutive differing synchronized samples required to accept a level change. Must be ≥1.
- CNT_W, 16: counter width. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- raw_in  input  WIDTH  asynchronous switch/button levels.
- clean_out  output  WIDTH  debounced levels.
- rise_pulse  output  WIDTH  1-cycle pulse when clean_out goes 0→1.
- fall_pulse  output  WIDTH  1-cycle pulse when clean_out goes 1→0.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high: rst, sampled on the clk rising edge. No asynchronous reset paths.
- Reset values (while rst=1 at an edge): sync flops, state, cnt, clean_out, rise_pulse and fall_pulse all 0. State = S0.
- Synchronizer: raw_in → s1 → sq on successive edges. The FSM observes sq only.
- Per-channel FSM states:
  - S0: stable low.
  - W01: qualifying a rise.
  - S1: stable high.
  - W10: qualifying a fall.
- cnt holds the number of consecutive differing sq samples seen, including the current one.
- Transitions:
  - In S0 with sq=1: if DEBOUNCE_CYCLES=1, commit immediately. Otherwise go to W01 with cnt=1.
  - In W01 with sq=1: if cnt+1 == DEBOUNCE_CYCLES, commit. Otherwise cnt++.
  - In W01 with sq=0: return to S0, cnt=0, no output change (glitch rejected).
  - S1 and W10 are symmetric, with sq=0 as the differing value.
- Commit (in the same edge):
  - clean_out toggles.
  - State goes to S1 or S0 accordingly.
  - cnt=0.
  - The matching pulse is 1 for exactly that one cycle.
- Latency: with raw stable after a change first sampled at edge e0, clean_out changes at edge e0+DEBOUNCE_CYCLES+1, i.e. DEBOUNCE_CYCLES+2 edges counting e0.
- Pulse rules:
  - rise_pulse and fall_pulse are never 1 simultaneously on one channel.
  - Otherwise they are 0 every cycle.
- Channels are fully independent. Simultaneous commits on different channels are allowed in the same cycle.
- cnt never exceeds DEBOUNCE_CYCLES-1, so it cannot wrap.
- Reset mid-operation:
  - Any partial qualification is discarded and outputs clear next edge.
  - If raw is held 1 through reset release, the channel re-qualifies from S0 and clean_out rises DEBOUNCE_CYCLES+2 edges after the first post-reset edge.
  - No pulses are emitted for reset-induced clearing.

Optional Feature:
- Macro: DEBOUNCE_EDGE_PULSE_EN.
- Defined: rise_pulse and fall_pulse behave as above.
- Undefined:
  - rise_pulse and fall_pulse remain declared but are tied constant 0.
  - No pulse registers are synthesized.
  - clean_out behaviour is identical in both builds.

Test Plan (DEBOUNCE_CYCLES=4):
1. Reset: rst=1 for 2 cycles with raw_in=2'b11 → clean_out=0 and both pulse vectors 0 during reset. After release, clean_out=2'b11 at the 6th edge after release. rise_pulse=2'b11 for that one cycle only.
2. Glitch rejection: raw_in[0] high for 3 cycles then low → clean_out[0] stays 0 and rise_pulse[0] stays 0 throughout.
3. Clean press/release: raw_in[1] 0→1 held 10 cycles, then 1→0 held 10 cycles → clean_out[1] rises at e0+5 with rise_pulse[1] for 1 cycle. Later it falls at e0'+5 with fall_pulse[1] for 1 cycle.
4. Bounce: raw_in[0] toggles 1,0,1,1,0,1 then holds 1 → clean_out[0] rises exactly 6 edges after the final 0→1 sample edge. Only one rise_pulse is emitted.
5. Reset mid-qualification: raw_in[1] high, rst asserted at cnt=2 → clean_out[1]=0 and no pulse. Re-qualification then completes 6 edges after rst drops.
6. Build without DEBOUNCE_EDGE_PULSE_EN, rerun scenario 3 → identical clean_out timing. rise_pulse and fall_pulse stay 0 every cycle.
